// File: rtl/piccolo128_seq_ctrl.sv
// Piccolo-128 iteration controller: whitening, round-core sequencing, output permutation.
// Optional abort input enabled by defining PICCOLO_CTRL_ABORT_EN.
// Bit numbering of data ports is MSB-first: spec bit i maps to vector bit (W-1-i).
module piccolo128_seq_ctrl #(
  parameter int unsigned ROUNDS = 31,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pt,
  input  logic [127:0]      in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_ct,
  output logic              busy,
  output logic [63:0]       core_state_o,
  output logic [127:0]      core_key_o,
  output logic [CNT_W-1:0]  core_rnd_o,
  output logic [CNT_W-1:0]  core_cnt_o,
  input  logic [63:0]       core_state_i,
  input  logic [127:0]      core_key_i
`ifdef PICCOLO_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [63:0]         st_q, st_d;
  logic [127:0]        key_q, key_d;
  logic [31:0]         wk_q, wk_d;
  logic [CNT_W-1:0]    rnd_q, rnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [63:0]         ct_q, ct_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic                abort_c;
  logic [15:0]         wk0_c, wk1_c, wk2_c, wk3_c;
  logic [63:0]         st_white_c;
  logic [63:0]         ct_perm_c;
  logic [SUM_W-1:0]    sum_c;

`ifdef PICCOLO_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Rounds the core must execute in the pass starting at round r.
  function automatic logic [CNT_W-1:0] pass_cnt(input logic [CNT_W-1:0] r);
    logic [SUM_W-1:0] rem;
    rem = SUM_W'(ROUNDS) - SUM_W'(r);
    if (rem > SUM_W'(UNROLL)) return CNT_W'(UNROLL);
    else                      return CNT_W'(rem);
  endfunction

  // Whitening keys and whitened input state.
  assign wk0_c      = {in_key[127:120], in_key[103:96]};
  assign wk1_c      = {in_key[111:104], in_key[119:112]};
  assign wk2_c      = {in_key[63:56],   in_key[7:0]};
  assign wk3_c      = {in_key[15:8],    in_key[55:48]};
  assign st_white_c = {in_pt[63:48] ^ wk0_c, in_pt[47:32], in_pt[31:16] ^ wk1_c, in_pt[15:0]};

  // Final byte permutation with output whitening of the core result.
  assign ct_perm_c = {{core_state_i[15:8], core_state_i[39:32]} ^ wk_q[31:16],
                      core_state_i[63:56], core_state_i[23:16],
                      {core_state_i[47:40], core_state_i[7:0]} ^ wk_q[15:0],
                      core_state_i[31:24], core_state_i[55:48]};

  assign sum_c = SUM_W'(rnd_q) + SUM_W'(cnt_q);

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    wk_d    = wk_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = st_white_c;
          key_d   = {in_key[95:0], in_key[127:96]};
          wk_d    = {wk2_c, wk3_c};
          rnd_d   = '0;
          cnt_d   = pass_cnt('0);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_c) begin
          rnd_d   = '0;
          state_d = S_IDLE;
        end else begin
          st_d  = core_state_i;
          key_d = core_key_i;
          rnd_d = CNT_W'(sum_c);
          if (sum_c == SUM_W'(ROUNDS)) begin
            ct_d    = ct_perm_c;
            state_d = S_DONE;
          end else begin
            cnt_d = pass_cnt(CNT_W'(sum_c));
          end
        end
      end
      S_DONE: begin
        if (abort_c) begin
          rnd_d   = '0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      key_q       <= '0;
      wk_q        <= '0;
      rnd_q       <= '0;
      cnt_q       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      key_q       <= key_d;
      wk_q        <= wk_d;
      rnd_q       <= rnd_d;
      cnt_q       <= cnt_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign out_ct       = ct_q;
  assign core_state_o = st_q;
  assign core_key_o   = key_q;
  assign core_rnd_o   = rnd_q;
  assign core_cnt_o   = cnt_q;

endmodule

// File: tb/tb_piccolo128_seq_ctrl.sv
// Bench for piccolo128_seq_ctrl: two instances (UNROLL=1 and UNROLL=7) each driving
// a behavioural toy round core; ciphertexts compared to a round-by-round reference.
module tb_piccolo128_seq_ctrl;

  localparam int ROUNDS = 31;

  typedef struct packed {
    logic [63:0]  s;
    logic [127:0] k;
  } sk_t;

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    int           d;
    int           hold;
    logic [63:0]  exp_ct;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         iv    [2];
  logic         ir    [2];
  logic [63:0]  pt_s  [2];
  logic [127:0] key_s [2];
  logic         ov    [2];
  logic         ordy  [2];
  logic [63:0]  ct    [2];
  logic         bsy   [2];
  logic [63:0]  cs_o  [2];
  logic [127:0] ck_o  [2];
  logic [4:0]   crnd  [2];
  logic [4:0]   ccnt  [2];
  logic [63:0]  cs_i  [2];
  logic [127:0] ck_i  [2];
`ifdef PICCOLO_CTRL_ABORT_EN
  logic         abort [2];
`endif

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One toy round: state mixes in upper key half and a round constant; key rotates.
  function automatic logic [63:0] toy_s(logic [63:0] s, logic [127:0] k, int r);
    return {s[50:0], s[63:51]} ^ k[127:64] ^ (64'(r + 1) * 64'h9E3779B97F4A7C15);
  endfunction

  function automatic logic [127:0] toy_k(logic [127:0] k, int r);
    return {k[118:0], k[127:119]} ^ 128'(r + 1);
  endfunction

  // Combinational round core: cnt rounds starting at round index rnd.
  function automatic sk_t core_fn(logic [63:0] s, logic [127:0] k, logic [4:0] r, logic [4:0] c);
    sk_t o;
    o.s = s;
    o.k = k;
    for (int j = 0; j < 32; j++) begin
      if (j < int'(c)) begin
        o.s = toy_s(o.s, o.k, int'(r) + j);
        o.k = toy_k(o.k, int'(r) + j);
      end
    end
    return o;
  endfunction

  // Byte starting at MSB-first bit index i of a w-bit value.
  function automatic logic [7:0] byte_at(logic [127:0] v, int w, int i);
    return v[w-1-i -: 8];
  endfunction

  // Reference: whitening, 31 sequential rounds, permutation + output whitening.
  function automatic logic [63:0] ref_ct(logic [63:0] pt, logic [127:0] key);
    logic [15:0]  wk0, wk1, wk2, wk3;
    logic [63:0]  s, s2;
    logic [127:0] k, x;
    wk0 = {byte_at(key, 128, 0),   byte_at(key, 128, 24)};
    wk1 = {byte_at(key, 128, 16),  byte_at(key, 128, 8)};
    wk2 = {byte_at(key, 128, 64),  byte_at(key, 128, 120)};
    wk3 = {byte_at(key, 128, 112), byte_at(key, 128, 72)};
    s = pt ^ {wk0, 16'h0, wk1, 16'h0};
    k = (key << 32) | (key >> 96);
    for (int r = 0; r < ROUNDS; r++) begin
      s2 = toy_s(s, k, r);
      k  = toy_k(k, r);
      s  = s2;
    end
    x = 128'(s);
    return {{byte_at(x, 64, 48), byte_at(x, 64, 24)} ^ wk2,
            byte_at(x, 64, 0), byte_at(x, 64, 40),
            {byte_at(x, 64, 16), byte_at(x, 64, 56)} ^ wk3,
            byte_at(x, 64, 32), byte_at(x, 64, 8)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sk_t core_res;
    assign core_res = core_fn(cs_o[g], ck_o[g], crnd[g], ccnt[g]);
    assign cs_i[g]  = core_res.s;
    assign ck_i[g]  = core_res.k;

    piccolo128_seq_ctrl #(.ROUNDS(31), .UNROLL(g == 0 ? 1 : 7), .CNT_W(5)) u_dut (
      .clk          (clk),
      .reset        (rst),
      .in_valid     (iv[g]),
      .in_ready     (ir[g]),
      .in_pt        (pt_s[g]),
      .in_key       (key_s[g]),
      .out_valid    (ov[g]),
      .out_ready    (ordy[g]),
      .out_ct       (ct[g]),
      .busy         (bsy[g]),
      .core_state_o (cs_o[g]),
      .core_key_o   (ck_o[g]),
      .core_rnd_o   (crnd[g]),
      .core_cnt_o   (ccnt[g]),
      .core_state_i (cs_i[g]),
      .core_key_i   (ck_i[g])
`ifdef PICCOLO_CTRL_ABORT_EN
      ,
      .abort        (abort[g])
`endif
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Offer one job on instance d, follow every pass, hold the result, then release.
  task automatic run_job(input int d, input logic [63:0] pt, input logic [127:0] key,
                         input int hold, input logic [63:0] exp);
    int u, p_cnt, n, rem;
    u     = (d == 0) ? 1 : 7;
    p_cnt = (ROUNDS + u - 1) / u;
    @(negedge clk);
    chk("accept_ready", 128'(ir[d]), 128'(1));
    iv[d]    = 1'b1;
    pt_s[d]  = pt;
    key_s[d] = key;
    ordy[d]  = (hold == 0);
    @(negedge clk);
    iv[d]    = 1'b0;
    pt_s[d]  = {$urandom(), $urandom()};
    key_s[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = 1;
    while (!ov[d] && n <= p_cnt + 4) begin
      if (n - 1 < p_cnt) begin
        rem = ROUNDS - (n - 1) * u;
        chk("core_rnd", 128'(crnd[d]), 128'((n - 1) * u));
        chk("core_cnt", 128'(ccnt[d]), 128'((rem < u) ? rem : u));
        chk("busy_run", 128'(bsy[d]), 128'(1));
        chk("ready_run", 128'(ir[d]), 128'(0));
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(p_cnt + 1));
    chk("out_ct", 128'(ct[d]), 128'(exp));
    chk("busy_done", 128'(bsy[d]), 128'(1));
    for (int i = 0; i < hold; i++) begin
      iv[d] = 1'b1;
      @(negedge clk);
      chk("hold_valid", 128'(ov[d]), 128'(1));
      chk("hold_ct", 128'(ct[d]), 128'(exp));
      chk("hold_ready", 128'(ir[d]), 128'(0));
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(negedge clk);
    chk("release_valid", 128'(ov[d]), 128'(0));
    chk("release_ready", 128'(ir[d]), 128'(1));
    ordy[d] = 1'b0;
  endtask

  vec_t         tbl [4];
  logic [63:0]  r_pt;
  logic [127:0] r_key;
  int           bad;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; pt_s[d] = '0; key_s[d] = '0;
`ifdef PICCOLO_CTRL_ABORT_EN
      abort[d] = 1'b0;
`endif
    end
    tbl[0] = '{64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff, 0, 0,  64'h0};
    tbl[1] = '{64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff, 1, 0,  64'h0};
    tbl[2] = '{64'hfedcba9876543210, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0, 10, 64'h0};
    tbl[3] = '{64'h0000000000000000, 128'hffffffffffffffffffffffffffffffff, 1, 10, 64'h0};
    for (int i = 0; i < 4; i++) tbl[i].exp_ct = ref_ct(tbl[i].pt, tbl[i].key);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_ready", 128'(ir[d]), 128'(1));
        chk("rst_valid", 128'(ov[d]), 128'(0));
        chk("rst_busy", 128'(bsy[d]), 128'(0));
        chk("rst_ct", 128'(ct[d]), 128'(0));
        chk("rst_rnd", 128'(crnd[d]), 128'(0));
      end
    end

    for (int i = 0; i < 4; i++)
      run_job(tbl[i].d, tbl[i].pt, tbl[i].key, tbl[i].hold, tbl[i].exp_ct);

    // Synchronous reset in the tenth RUN cycle discards the job.
    @(negedge clk);
    iv[0] = 1'b1; pt_s[0] = tbl[2].pt; key_s[0] = tbl[2].key; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 128'(bsy[0]), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 128'(ir[0]), 128'(1));
    chk("midrst_valid", 128'(ov[0]), 128'(0));
    chk("midrst_busy", 128'(bsy[0]), 128'(0));
    bad = 0;
    repeat (35) begin
      @(negedge clk);
      if (ov[0]) bad++;
    end
    chk("midrst_no_valid", 128'(bad), 128'(0));
    ordy[0] = 1'b0;
    run_job(0, tbl[0].pt, tbl[0].key, 2, tbl[0].exp_ct);

    // Randomized jobs on both instances.
    for (int i = 0; i < 8; i++) begin
      r_pt  = {$urandom(), $urandom()};
      r_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_job(i % 2, r_pt, r_key, int'($urandom_range(0, 3)), ref_ct(r_pt, r_key));
    end

`ifdef PICCOLO_CTRL_ABORT_EN
    // Abort in the third RUN cycle.
    @(negedge clk);
    iv[0] = 1'b1; pt_s[0] = tbl[0].pt; key_s[0] = tbl[0].key; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_run_ready", 128'(ir[0]), 128'(1));
    chk("abort_run_busy", 128'(bsy[0]), 128'(0));
    chk("abort_run_rnd", 128'(crnd[0]), 128'(0));
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) bad++;
    end
    chk("abort_run_no_valid", 128'(bad), 128'(0));
    ordy[0] = 1'b0;

    // Abort together with out_ready in DONE.
    @(negedge clk);
    iv[1] = 1'b1; pt_s[1] = tbl[1].pt; key_s[1] = tbl[1].key; ordy[1] = 1'b0;
    @(negedge clk);
    iv[1] = 1'b0;
    bad = 0;
    while (!ov[1] && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("abort_done_reach", 128'(ov[1]), 128'(1));
    abort[1] = 1'b1; ordy[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    chk("abort_done_valid", 128'(ov[1]), 128'(0));
    chk("abort_done_ready", 128'(ir[1]), 128'(1));
    @(negedge clk);
    chk("abort_done_stay", 128'(ov[1]), 128'(0));
    ordy[1] = 1'b0;
    run_job(1, tbl[3].pt, tbl[3].key, 1, tbl[3].exp_ct);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
